mojo_com_rx_assembler: RTL and testbench

Receive-side framer for the host serial link. Collects a stream of bytes from the UART byte receiver (data plus one-cycle valid strobe) into a DATA_SIZE-byte array. Publishes the array to core logic with a one-cycle strobe.
Sits between the serial_rx byte receiver and the register/command logic. It is the counterpart of the array-to-byte transmit path.
A partial frame is abandoned after an inter-byte silence timeout, so a dropped byte cannot misalign later frames.

---
 rtl/mojo_com_rx_assembler_pkg.sv | 19 +
 rtl/mojo_com_rx_assembler_if.sv | 24 ++
 rtl/mojo_com_rx_assembler_timer.sv | 32 +++
 rtl/mojo_com_rx_assembler.sv | 92 +++++++++
 tb/tb_mojo_com_rx_assembler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mojo_com_rx_assembler_pkg.sv
// Shared definitions for the host serial link framers (receive and transmit paths).
package com_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } com_state_t;

    // Elaboration-time ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mojo_com_rx_assembler_if.sv
// Byte-in / frame-out bundle between the UART byte receiver and the frame assembler.
interface mojo_com_rx_assembler_if
    import com_pkg::*;
#(
    parameter int DATA_SIZE = 16
);
    logic [BYTE_W-1:0]           rx_data;
    logic                        new_rx_data;
    logic                        clear;
    logic [DATA_SIZE*BYTE_W-1:0] rx_arr;
    logic                        new_rx;
    logic                        rx_busy;
    logic                        timeout;

    modport master (
        output rx_data, new_rx_data, clear,
        input  rx_arr, new_rx, rx_busy, timeout
    );

    modport slave (
        input  rx_data, new_rx_data, clear,
        output rx_arr, new_rx, rx_busy, timeout
    );
endinterface

// File: rtl/mojo_com_rx_assembler_timer.sv
// Inter-byte silence timer: counts idle cycles while a partial frame is held.
module com_silence_timer
    import com_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit  = run && !kick && (r_cnt == LAST_CNT);
    assign expire = w_hit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run || kick || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mojo_com_rx_assembler.sv
// Receive framer: packs DATA_SIZE strobed bytes into rx_arr, abandoning partial frames on silence.
module mojo_com_rx_assembler
    import com_pkg::*;
#(
    parameter int DATA_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mojo_com_rx_assembler_if.slave rx_if
);
    localparam int BUF_W = DATA_SIZE * BYTE_W;
    localparam int IDX_W = (clog2(DATA_SIZE) < 1) ? 1 : clog2(DATA_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

    com_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [BUF_W-1:0] r_buf;
    logic [BUF_W-1:0] r_rx_arr;
    logic             r_new_rx;
    logic             r_busy;
    logic             r_timeout;

    logic [BUF_W-1:0] w_buf_next;
    logic             w_last;
    logic             w_expire;

    com_silence_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (r_state == ST_RECV),
        .kick  (rx_if.new_rx_data || rx_if.clear),
        .expire(w_expire)
    );

    // In IDLE r_idx is always 0, so the same slot select serves the first byte.
    assign w_last = (r_idx == LAST_IDX);

    // NOTE: default the whole vector first so the conditional byte write cannot infer a latch.
    always_comb begin
        w_buf_next = r_buf;
        for (int k = 0; k < DATA_SIZE; k++) begin
            if (r_idx == IDX_W'(k)) w_buf_next[k*BYTE_W +: BYTE_W] = rx_if.rx_data;
        end
    end

    // NOTE: the assembly buffer is a register bank, not a RAM, so it takes the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_buf     <= '0;
            r_rx_arr  <= '0;
            r_new_rx  <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_new_rx  <= 1'b0;
            r_timeout <= 1'b0;
            if (rx_if.clear) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_busy  <= 1'b0;
            end else if (rx_if.new_rx_data) begin
                r_buf <= w_buf_next;
                if (w_last) begin
                    r_rx_arr <= w_buf_next;
                    r_new_rx <= 1'b1;
                    r_state  <= ST_IDLE;
                    r_idx    <= '0;
                    r_busy   <= 1'b0;
                end else begin
                    r_state  <= ST_RECV;
                    r_idx    <= r_idx + 1'b1;
                    r_busy   <= 1'b1;
                end
            end else if (w_expire) begin
                r_state   <= ST_IDLE;
                r_idx     <= '0;
                r_busy    <= 1'b0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign rx_if.rx_arr  = r_rx_arr;
    assign rx_if.new_rx  = r_new_rx;
    assign rx_if.rx_busy = r_busy;
    assign rx_if.timeout = r_timeout;
endmodule

// File: tb/tb_mojo_com_rx_assembler.sv
// Bench for mojo_com_rx_assembler: a 4-byte and a 1-byte framer driven in lockstep against a frame model.
module tb_mojo_com_rx_assembler;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    mojo_com_rx_assembler_if #(.DATA_SIZE(4)) if4 ();
    mojo_com_rx_assembler_if #(.DATA_SIZE(1)) if1 ();

    mojo_com_rx_assembler #(.DATA_SIZE(4), .TIMEOUT_CYCLES(TO)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx_if(if4.slave)
    );
    mojo_com_rx_assembler #(.DATA_SIZE(1), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_if(if1.slave)
    );

    always #5 clk = ~clk;

    // Frame model per instance: bytes collected so far, silent cycles since last byte.
    int         ds   [2] = '{4, 1};
    logic [7:0] fb   [2][4];
    int         fill [2];
    int         sil  [2];
    logic [31:0] e_arr [2];
    logic        e_new [2];
    logic        e_busy[2];
    logic        e_to  [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            fill[m] = 0; sil[m] = 0; e_arr[m] = '0;
            e_new[m] = 1'b0; e_busy[m] = 1'b0; e_to[m] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] b, input logic s, input logic c);
        for (int m = 0; m < 2; m++) begin
            e_new[m] = 1'b0;
            e_to[m]  = 1'b0;
            if (c) begin
                fill[m] = 0; sil[m] = 0;
            end else if (s) begin
                fb[m][fill[m]] = b;
                fill[m]++;
                sil[m] = 0;
                if (fill[m] == ds[m]) begin
                    e_arr[m] = '0;
                    for (int k = 0; k < ds[m]; k++) e_arr[m][8*k +: 8] = fb[m][k];
                    e_new[m] = 1'b1;
                    fill[m]  = 0;
                end
            end else if (fill[m] > 0) begin
                sil[m]++;
                if (sil[m] == TO) begin
                    fill[m] = 0; sil[m] = 0; e_to[m] = 1'b1;
                end
            end
            e_busy[m] = (fill[m] > 0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("arr4",  if4.rx_arr,             e_arr[0]);
        chk("new4",  32'(if4.new_rx),        32'(e_new[0]));
        chk("busy4", 32'(if4.rx_busy),       32'(e_busy[0]));
        chk("to4",   32'(if4.timeout),       32'(e_to[0]));
        chk("arr1",  {24'h0, if1.rx_arr},    e_arr[1]);
        chk("new1",  32'(if1.new_rx),        32'(e_new[1]));
        chk("busy1", 32'(if1.rx_busy),       32'(e_busy[1]));
        chk("to1",   32'(if1.timeout),       32'(e_to[1]));
    endtask

    // Drive one cycle of input just after a falling edge, then check at the next falling edge.
    task automatic step(input logic [7:0] b, input logic s, input logic c);
        if4.rx_data = b; if4.new_rx_data = s; if4.clear = c;
        if1.rx_data = b; if1.new_rx_data = s; if1.clear = c;
        model_step(b, s, c);
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1, 1'b0);
    endtask

    initial begin
        if4.rx_data = '0; if4.new_rx_data = 1'b0; if4.clear = 1'b0;
        if1.rx_data = '0; if1.new_rx_data = 1'b0; if1.clear = 1'b0;
        model_reset();
        #12;
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 4-byte frame.
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("frame_11_44", if4.rx_arr, 32'h44332211);
        chk("frame_11_44_pulse", 32'(if4.new_rx), 32'd1);
        idle(2);

        // Partial frame abandoned by silence, then a clean frame.
        send(8'hAA); send(8'hBB);
        idle(TO + 2);
        chk("timeout_keeps_arr", if4.rx_arr, 32'h44332211);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("frame_after_timeout", if4.rx_arr, 32'h04030201);
        idle(1);

        // Byte lands exactly on the expiry cycle: it wins.
        send(8'hAA); send(8'hBB);
        idle(TO - 1);
        send(8'hCC);
        chk("no_timeout_on_byte", 32'(if4.timeout), 32'd0);
        send(8'hDD);
        chk("frame_on_expiry", if4.rx_arr, 32'hDDCCBBAA);
        idle(1);

        // Single-byte frames back to back.
        send(8'h5A);
        chk("ds1_first", {24'h0, if1.rx_arr}, 32'h5A);
        send(8'hA5);
        chk("ds1_second", {24'h0, if1.rx_arr}, 32'hA5);
        chk("ds1_second_pulse", 32'(if1.new_rx), 32'd1);
        idle(TO + 2);

        // Asynchronous reset mid-frame, between clock edges.
        send(8'h01); send(8'h02);
        if4.new_rx_data = 1'b0; if1.new_rx_data = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
        chk("frame_after_reset", if4.rx_arr, 32'hF0DEBC9A);
        idle(1);

        // Clear together with the third byte drops it.
        send(8'h31); send(8'h32);
        step(8'h33, 1'b1, 1'b1);
        chk("clear_busy", 32'(if4.rx_busy), 32'd0);
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        chk("frame_after_clear", if4.rx_arr, 32'hC4C3C2C1);
        idle(1);

        // Random bursts, gaps and clears checked against the model.
        for (int i = 0; i < 60; i++) begin
            int burst;
            burst = $urandom_range(1, 6);
            for (int j = 0; j < burst; j++) begin
                step(8'($urandom), 1'b1, ($urandom_range(0, 15) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(TO - 2, TO + 3));
        end
        idle(TO + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
